im_loader: RTL and testbench

IM_LOADER -- requirements
Module: im_loader

---
 rtl/im_loader.sv | 175 +++++++++++++++++
 tb/tb_im_loader.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/im_loader.sv
// Instruction-memory loader: receives a byte stream, packs it big-endian into 32-bit words and
// writes them to sequential word addresses, holding the CPU in reset until a good image lands.
// Optional feature macro: IM_LOADER_CKSUM_EN (adds a trailing XOR checksum byte and CKSUM state).
module im_loader #(
    parameter int unsigned IM_WORDS  = 1024,
    parameter int unsigned MAX_LEN_W = 11
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [MAX_LEN_W-1:0] len,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    output logic                 we,
    output logic [11:2]          wr_addr,
    output logic [31:0]          wr_data,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 cpu_hold
);

    localparam logic [MAX_LEN_W-1:0] ImWordsL = MAX_LEN_W'(IM_WORDS);
    localparam logic [MAX_LEN_W-1:0] OneL     = MAX_LEN_W'(1);

`ifdef IM_LOADER_CKSUM_EN
    typedef enum logic [2:0] {StIdle, StRecv, StWrite, StDone, StCksum} state_e;
`else
    typedef enum logic [2:0] {StIdle, StRecv, StWrite, StDone} state_e;
`endif

    state_e                 state_q;
    logic [MAX_LEN_W-1:0]   len_q;
    logic [MAX_LEN_W-1:0]   word_cnt_q;
    logic [1:0]             byte_cnt_q;
    // Only the first three bytes need holding; the fourth goes straight into wr_data.
    logic [23:0]            shift_q;
    logic                   rx_ready_q;
    logic                   we_q;
    logic [11:2]            wr_addr_q;
    logic [31:0]            wr_data_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   err_q;
    logic                   cpu_hold_q;
`ifdef IM_LOADER_CKSUM_EN
    logic [7:0]             acc_q;
`endif

    logic        len_ok;
    logic        rx_fire;
    logic [31:0] shift_nxt;
    logic        last_word;

    // Decode helpers shared by the FSM.
    always_comb begin
        len_ok    = (len != '0) && (len <= ImWordsL);
        rx_fire   = rx_valid && rx_ready_q;
        shift_nxt = {shift_q, rx_data};
        last_word = (word_cnt_q == (len_q - OneL));
    end

    // Loader FSM with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            len_q      <= '0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            rx_ready_q <= 1'b0;
            we_q       <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cpu_hold_q <= 1'b1;
`ifdef IM_LOADER_CKSUM_EN
            acc_q      <= '0;
`endif
        end else begin
            we_q <= 1'b0;
            unique case (state_q)
                // Start is honoured only when idle or finished; busy states ignore it.
                StIdle, StDone: begin
                    if (start) begin
                        len_q      <= len;
                        word_cnt_q <= '0;
                        byte_cnt_q <= '0;
                        shift_q    <= '0;
                        cpu_hold_q <= 1'b1;
`ifdef IM_LOADER_CKSUM_EN
                        acc_q      <= '0;
`endif
                        if (len_ok) begin
                            state_q    <= StRecv;
                            rx_ready_q <= 1'b1;
                            busy_q     <= 1'b1;
                            done_q     <= 1'b0;
                            err_q      <= 1'b0;
                        end else begin
                            state_q    <= StDone;
                            rx_ready_q <= 1'b0;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            err_q      <= 1'b1;
                        end
                    end
                end
                StRecv: begin
                    if (rx_fire) begin
                        shift_q    <= shift_nxt[23:0];
                        byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef IM_LOADER_CKSUM_EN
                        acc_q      <= acc_q ^ rx_data;
`endif
                        if (byte_cnt_q == 2'd3) begin
                            state_q    <= StWrite;
                            rx_ready_q <= 1'b0;
                            we_q       <= 1'b1;
                            wr_addr_q  <= word_cnt_q[9:0];
                            wr_data_q  <= shift_nxt;
                        end
                    end
                end
                StWrite: begin
                    if (last_word) begin
`ifdef IM_LOADER_CKSUM_EN
                        state_q    <= StCksum;
                        rx_ready_q <= 1'b1;
`else
                        state_q    <= StDone;
                        rx_ready_q <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        err_q      <= 1'b0;
                        cpu_hold_q <= 1'b0;
`endif
                    end else begin
                        word_cnt_q <= word_cnt_q + OneL;
                        state_q    <= StRecv;
                        rx_ready_q <= 1'b1;
                    end
                end
`ifdef IM_LOADER_CKSUM_EN
                StCksum: begin
                    if (rx_fire) begin
                        state_q    <= StDone;
                        rx_ready_q <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        err_q      <= (rx_data != acc_q);
                        cpu_hold_q <= (rx_data != acc_q);
                    end
                end
`endif
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign rx_ready = rx_ready_q;
    assign we       = we_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign cpu_hold = cpu_hold_q;

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: directed and randomized loads checked against a
// byte-stream model (big-endian packing, sequential addresses, optional XOR checksum).
module tb_im_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [10:0] len;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        we;
    logic [11:2] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        err;
    logic        cpu_hold;

    int          vectors = 0;
    int          miscompares = 0;
    int          we_cnt = 0;
    int          stall_idx = -1;
    logic [7:0]  byte_buf [0:4095];

    im_loader #(.IM_WORDS(1024), .MAX_LEN_W(11)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .len      (len),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .we       (we),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .cpu_hold (cpu_hold)
    );

    always #5 clk = ~clk;

    // Count write strobes; we is registered so its value here is the finished cycle's.
    always @(posedge clk) if (we === 1'b1) we_cnt <= we_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals();
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_we",       32'(we),       32'd0);
        check("rst_wr_addr",  32'(wr_addr),  32'd0);
        check("rst_wr_data",  wr_data,       32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_done",     32'(done),     32'd0);
        check("rst_err",      32'(err),      32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    endtask

    // Offer one byte after an idle gap; returns at the negedge following its handshake.
    task automatic send_byte(input logic [7:0] b, input int unsigned gap, input bit inject);
        int n;
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        if (inject) begin
            start = 1'b1;
            len   = 11'($urandom_range(0, 2047));
        end
        n = 0;
        while (rx_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rx_ready_wait", 32'(rx_ready), 32'd1);
        @(negedge clk);
        rx_valid = 1'b0;
        start    = 1'b0;
    endtask

    // Full load of n words from byte_buf; expected words and checksum from plain arithmetic.
    task automatic run_load(input int unsigned n, input int unsigned gapmax, input bit inject,
                            input bit bad_ck);
        int          base;
        logic [7:0]  ck;
        logic [31:0] word;
        logic        exp_err;
        int unsigned gap;
        base = we_cnt;
        ck   = 8'h00;
        start = 1'b1;
        len   = 11'(n);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        check("done_cleared",     32'(done), 32'd0);
        check("err_cleared",      32'(err),  32'd0);
        for (int w = 0; w < int'(n); w++) begin
            word = 32'd0;
            for (int k = 0; k < 4; k++) begin
                ck   = ck ^ byte_buf[4*w+k];
                word = (word << 8) + 32'(byte_buf[4*w+k]);
                gap  = (4*w+k == stall_idx) ? 5 : $urandom_range(0, gapmax);
                send_byte(byte_buf[4*w+k], gap, inject);
            end
            check("we_after_4th",    32'(we),       32'd1);
            check("wr_addr",         32'(wr_addr),  32'(w));
            check("wr_data",         wr_data,       word);
            check("rx_ready_bubble", 32'(rx_ready), 32'd0);
        end
`ifdef IM_LOADER_CKSUM_EN
        send_byte(bad_ck ? (ck ^ 8'h01) : ck, 0, 1'b0);
        exp_err = bad_ck;
`else
        @(negedge clk);
        exp_err = 1'b0;
`endif
        check("done_end",     32'(done),       32'd1);
        check("err_end",      32'(err),        32'(exp_err));
        check("cpu_hold_end", 32'(cpu_hold),   32'(exp_err));
        check("busy_end",     32'(busy),       32'd0);
        check("we_count",     32'(we_cnt - base), 32'(n));
    endtask

    task automatic bad_len(input logic [10:0] l);
        int base;
        base  = we_cnt;
        start = 1'b1;
        len   = l;
        @(negedge clk);
        start = 1'b0;
        check("badlen_done",     32'(done),     32'd1);
        check("badlen_err",      32'(err),      32'd1);
        check("badlen_cpu_hold", 32'(cpu_hold), 32'd1);
        check("badlen_busy",     32'(busy),     32'd0);
        repeat (4) @(negedge clk);
        check("badlen_no_we",    32'(we_cnt - base), 32'd0);
        check("badlen_hold",     32'(cpu_hold), 32'd1);
    endtask

    initial begin
        logic [7:0] dir_bytes [0:7];
        reset    = 1'b1;
        start    = 1'b0;
        len      = '0;
        rx_data  = '0;
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals();
        reset = 1'b0;
        @(negedge clk);

        // Directed two-word load with back-to-back bytes.
        dir_bytes = '{8'h34, 8'h08, 8'h00, 8'h01, 8'h20, 8'h09, 8'h00, 8'h02};
        for (int i = 0; i < 8; i++) byte_buf[i] = dir_bytes[i];
        run_load(2, 0, 1'b0, 1'b0);

        // Bytes offered while DONE are not consumed.
        rx_valid = 1'b1;
        rx_data  = 8'hAA;
        repeat (3) @(negedge clk);
        check("done_rx_ready", 32'(rx_ready), 32'd0);
        check("done_holds",    32'(done),     32'd1);
        rx_valid = 1'b0;

        // Illegal lengths.
        bad_len(11'd0);
        bad_len(11'd1025);

        // Stall after the second byte.
        for (int i = 0; i < 4; i++) byte_buf[i] = 8'($urandom);
        stall_idx = 2;
        run_load(1, 0, 1'b0, 1'b0);
        stall_idx = -1;

        // Reset mid-word, then a fresh single-word load.
        for (int i = 0; i < 12; i++) byte_buf[i] = 8'($urandom);
        start = 1'b1;
        len   = 11'd3;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 6; i++) send_byte(byte_buf[i], 0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals();
        reset = 1'b0;
        run_load(1, 1, 1'b0, 1'b0);

        // Randomized loads with random gaps.
        for (int t = 0; t < 5; t++) begin
            int unsigned n;
            n = $urandom_range(1, 8);
            for (int i = 0; i < int'(4*n); i++) byte_buf[i] = 8'($urandom);
            run_load(n, 3, 1'b0, 1'b0);
        end

`ifdef IM_LOADER_CKSUM_EN
        dir_bytes[0:3] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) byte_buf[i] = dir_bytes[i];
        run_load(1, 0, 1'b0, 1'b0);
        run_load(1, 0, 1'b0, 1'b1);
`endif

        // Full-depth load with start pulses injected mid-load.
        for (int i = 0; i < 4096; i++) byte_buf[i] = 8'($urandom);
        run_load(1024, 0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
